// File: rtl/ram64_arbiter_if.sv
// Bundle of requester A/B handshakes, clear control and the ram64 port.
// The arbiter uses the slave view; requesters plus the RAM use the master view.
interface ram64_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  a_req;
    logic                  a_load;
    logic [ADDR_WIDTH-1:0] a_address;
    logic [DATA_WIDTH-1:0] a_in;
    logic                  a_ack;
    logic [DATA_WIDTH-1:0] a_out;

    logic                  b_req;
    logic                  b_load;
    logic [ADDR_WIDTH-1:0] b_address;
    logic [DATA_WIDTH-1:0] b_in;
    logic                  b_ack;
    logic [DATA_WIDTH-1:0] b_out;

    logic                  clr_start;
    logic                  clr_busy;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_in;
    logic                  ram_load;
    logic [DATA_WIDTH-1:0] ram_out;

    modport slave (
        input  a_req, a_load, a_address, a_in,
        input  b_req, b_load, b_address, b_in,
        input  clr_start,
        input  ram_out,
        output a_ack, a_out, b_ack, b_out,
        output clr_busy,
        output ram_address, ram_in, ram_load
    );

    modport master (
        output a_req, a_load, a_address, a_in,
        output b_req, b_load, b_address, b_in,
        output clr_start,
        output ram_out,
        input  a_ack, a_out, b_ack, b_out,
        input  clr_busy,
        input  ram_address, ram_in, ram_load
    );
endinterface

// File: rtl/ram64_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single ram64, with a
// hardware sweep that writes CLEAR_VALUE to every word.
module ram64_arbiter #(
    parameter int                     ADDR_WIDTH  = 6,
    parameter int                     DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    ram64_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_e;

    localparam logic                  ID_A      = 1'b0;
    localparam logic                  ID_B      = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                state_q,       state_d;
    logic                  last_grant_q,  last_grant_d;
    logic                  clr_pending_q, clr_pending_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q,     clr_cnt_d;
    logic                  cmd_id_q,      cmd_id_d;

    logic                  a_ack_q,       a_ack_d;
    logic [DATA_WIDTH-1:0] a_out_q,       a_out_d;
    logic                  b_ack_q,       b_ack_d;
    logic [DATA_WIDTH-1:0] b_out_q,       b_out_d;
    logic                  clr_busy_q,    clr_busy_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_in_q,      ram_in_d;
    logic                  ram_load_q,    ram_load_d;

    logic                  grant_id_d;
    logic                  win_load_d;
    logic [ADDR_WIDTH-1:0] win_address_d;
    logic [DATA_WIDTH-1:0] win_in_d;
    logic [DATA_WIDTH-1:0] ack_data_d;

    // Winner selection: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        grant_id_d = ID_A;
        if (bus.a_req && bus.b_req) begin
            grant_id_d = ~last_grant_q;
        end else if (bus.b_req) begin
            grant_id_d = ID_B;
        end else begin
            grant_id_d = ID_A;
        end

        if (grant_id_d == ID_B) begin
            win_load_d    = bus.b_load;
            win_address_d = bus.b_address;
            win_in_d      = bus.b_in;
        end else begin
            win_load_d    = bus.a_load;
            win_address_d = bus.a_address;
            win_in_d      = bus.a_in;
        end
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        clr_pending_d = clr_pending_q;
        clr_cnt_d     = clr_cnt_q;
        cmd_id_d      = cmd_id_q;
        a_ack_d       = 1'b0;
        a_out_d       = a_out_q;
        b_ack_d       = 1'b0;
        b_out_d       = b_out_q;
        ram_address_d = ADDR_ZERO;
        ram_in_d      = DATA_ZERO;
        ram_load_d    = 1'b0;
        ack_data_d    = DATA_ZERO;

        case (state_q)
            ST_IDLE: begin
                if (clr_pending_q) begin
                    state_d       = ST_CLEAR;
                    clr_cnt_d     = ADDR_ZERO;
                    ram_load_d    = 1'b1;
                    ram_address_d = ADDR_ZERO;
                    ram_in_d      = CLEAR_VALUE;
                end else if (bus.a_req || bus.b_req) begin
                    // The registered RAM port doubles as the latched command.
                    state_d       = ST_ACCESS;
                    cmd_id_d      = grant_id_d;
                    last_grant_d  = grant_id_d;
                    ram_load_d    = win_load_d;
                    ram_address_d = win_address_d;
                    ram_in_d      = win_in_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                state_d = ST_DONE;
                if (ram_load_q) begin
                    ack_data_d = ram_in_q;
                end else begin
                    ack_data_d = bus.ram_out;
                end
                if (cmd_id_q == ID_B) begin
                    b_ack_d = 1'b1;
                    b_out_d = ack_data_d;
                end else begin
                    a_ack_d = 1'b1;
                    a_out_d = ack_data_d;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_CLEAR: begin
                if (clr_cnt_q == ADDR_LAST) begin
                    state_d       = ST_IDLE;
                    clr_pending_d = 1'b0;
                end else begin
                    clr_cnt_d     = clr_cnt_q + ADDR_ONE;
                    ram_load_d    = 1'b1;
                    ram_address_d = clr_cnt_q + ADDR_ONE;
                    ram_in_d      = CLEAR_VALUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A start pulse during a sweep must not queue a second sweep.
        clr_pending_d = clr_pending_d | (bus.clr_start & (state_q != ST_CLEAR));
        clr_busy_d    = clr_pending_d | (state_d == ST_CLEAR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= ID_B;
            clr_pending_q <= 1'b0;
            clr_cnt_q     <= ADDR_ZERO;
            cmd_id_q      <= ID_A;
            a_ack_q       <= 1'b0;
            a_out_q       <= DATA_ZERO;
            b_ack_q       <= 1'b0;
            b_out_q       <= DATA_ZERO;
            clr_busy_q    <= 1'b0;
            ram_address_q <= ADDR_ZERO;
            ram_in_q      <= DATA_ZERO;
            ram_load_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            clr_pending_q <= clr_pending_d;
            clr_cnt_q     <= clr_cnt_d;
            cmd_id_q      <= cmd_id_d;
            a_ack_q       <= a_ack_d;
            a_out_q       <= a_out_d;
            b_ack_q       <= b_ack_d;
            b_out_q       <= b_out_d;
            clr_busy_q    <= clr_busy_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            ram_load_q    <= ram_load_d;
        end
    end

    assign bus.a_ack       = a_ack_q;
    assign bus.a_out       = a_out_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.b_out       = b_out_q;
    assign bus.clr_busy    = clr_busy_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_in      = ram_in_q;
    assign bus.ram_load    = ram_load_q;

    ram64_arbiter_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .a_ack    (a_ack_q),
        .b_ack    (b_ack_q),
        .ram_load (ram_load_q)
    );

endmodule

// Acks are mutually exclusive and never share a cycle with a RAM write.
module ram64_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic a_ack,
    input logic b_ack,
    input logic ram_load
);
    ack_onehot_a: assert property (@(posedge clk) disable iff (reset) !(a_ack && b_ack));
    ack_no_load_a: assert property (@(posedge clk) disable iff (reset) (a_ack || b_ack) |-> !ram_load);
endmodule

// File: tb/tb_ram64_arbiter.sv
// Scoreboard bench for ram64_arbiter: a behavioural ram64, a reference memory
// and per-port expectation queues drained by an ack monitor.
module tb_ram64_arbiter;
    localparam int          AW      = 6;
    localparam int          DW      = 16;
    localparam logic [15:0] CLR_VAL = 16'h0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram64_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram64_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CLR_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural ram64: combinational read, write on the edge when load is high.
    logic [15:0] ram_mem [64];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= 16'hA000 + 16'(i);
            mem_ready <= 1'b1;
        end else if (bus.ram_load) begin
            ram_mem[bus.ram_address] <= bus.ram_in;
        end
    end
    assign bus.ram_out = ram_mem[bus.ram_address];

    logic [15:0] ref_mem [64];
    logic [15:0] exp_a_q [$];
    logic [15:0] exp_b_q [$];
    int          order_log [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          load_cnt = 0;
    int          busy_fall_cyc = 0;
    int          b_ack_cyc = 0;
    logic        busy_prev = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one transaction on a port, push its expected result, wait for ack.
    task automatic issue(input bit port, input bit load, input logic [5:0] addr,
                         input logic [15:0] data, output int lat);
        logic [15:0] e;
        bit          acked;
        if (load) begin
            ref_mem[addr] = data;
            e = data;
        end else begin
            e = ref_mem[addr];
        end
        if (port == 1'b0) begin
            bus.a_req = 1'b1; bus.a_load = load; bus.a_address = addr; bus.a_in = data;
            exp_a_q.push_back(e);
        end else begin
            bus.b_req = 1'b1; bus.b_load = load; bus.b_address = addr; bus.b_in = data;
            exp_b_q.push_back(e);
        end
        lat   = 0;
        acked = 1'b0;
        while (!acked && lat < 300) begin
            @(negedge clk);
            lat++;
            acked = port ? bus.b_ack : bus.a_ack;
        end
        if (!acked) check_value(port ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
        if (port == 1'b0) bus.a_req = 1'b0;
        else              bus.b_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_a_ack"}, bus.a_ack, 32'd0);
        check_value({tag, "_b_ack"}, bus.b_ack, 32'd0);
        check_value({tag, "_clr_busy"}, bus.clr_busy, 32'd0);
        check_value({tag, "_ram_load"}, bus.ram_load, 32'd0);
        check_value({tag, "_ram_address"}, bus.ram_address, 32'd0);
        check_value({tag, "_ram_in"}, bus.ram_in, 32'd0);
        check_value({tag, "_a_out"}, bus.a_out, 32'd0);
        check_value({tag, "_b_out"}, bus.b_out, 32'd0);
    endtask

    // Ack monitor: pops the per-port scoreboard and logs grant order.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.ram_load) load_cnt = load_cnt + 1;
        if (busy_prev && !bus.clr_busy) busy_fall_cyc = cyc;
        busy_prev = bus.clr_busy;
        if (bus.a_ack || bus.b_ack) check_value("ack_onehot", {31'd0, bus.a_ack & bus.b_ack}, 32'd0);
        if (bus.a_ack) begin
            order_log.push_back(0);
            if (exp_a_q.size() == 0) check_value("a_unexpected_ack", 32'd1, 32'd0);
            else                     check_value("a_out", bus.a_out, exp_a_q.pop_front());
        end
        if (bus.b_ack) begin
            order_log.push_back(1);
            b_ack_cyc = cyc;
            if (exp_b_q.size() == 0) check_value("b_unexpected_ack", 32'd1, 32'd0);
            else                     check_value("b_out", bus.b_out, exp_b_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, la, lb, l0, idx, bc, ei, bad, first_k, last_k;
        bit found;

        for (int i = 0; i < 64; i++) ref_mem[i] = 16'hA000 + 16'(i);
        bus.a_req = 1'b0; bus.a_load = 1'b0; bus.a_address = 6'd0; bus.a_in = 16'd0;
        bus.b_req = 1'b0; bus.b_load = 1'b0; bus.b_address = 6'd0; bus.b_in = 16'd0;
        bus.clr_start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("rst");

        // Single-port write then read-back.
        l0 = load_cnt;
        issue(1'b0, 1'b1, 6'd5, 16'd1234, lat);
        #1;
        check_value("t1_wr_latency", lat, 32'd2);
        check_value("t1_wr_load_cycles", load_cnt - l0, 32'd1);
        issue(1'b0, 1'b0, 6'd5, 16'd0, lat);
        check_value("t1_rd_latency", lat, 32'd3);
        @(negedge clk);
        check_value("t1_a_out_hold", bus.a_out, 32'd1234);
        check_value("t1_a_ack_low", bus.a_ack, 32'd0);

        // Simultaneous requests: A first after reset, then strict alternation.
        do_reset();
        fork
            begin int l; issue(1'b0, 1'b1, 6'd10, 16'd100, l); la = l; end
            begin int l; issue(1'b1, 1'b1, 6'd20, 16'd200, l); lb = l; end
        join
        check_value("t2_a_latency", la, 32'd2);
        check_value("t2_b_latency", lb, 32'd5);
        #1;
        idx = order_log.size();
        fork
            begin int l; for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, 6'(11 + i), 16'h0A00 + 16'(i), l); end
            begin int l; for (int i = 0; i < 3; i++) issue(1'b1, 1'b1, 6'(21 + i), 16'h0B00 + 16'(i), l); end
        join
        #1;
        check_value("t2_order_count", order_log.size() - idx, 32'd6);
        if (order_log.size() - idx == 6)
            for (int k = 0; k < 6; k++) check_value("t2_alternation", order_log[idx + k], k % 2);

        // Lone B requester is served every third cycle; a new A then wins the tie.
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b0, 6'(20 + i), 16'd0, lat);
            check_value("t3_b_period", lat, 32'd3);
        end
        #1;
        idx = order_log.size();
        fork
            begin int l; issue(1'b0, 1'b0, 6'd10, 16'd0, l); la = l; end
            begin int l; issue(1'b1, 1'b0, 6'd23, 16'd0, l); lb = l; end
        join
        #1;
        check_value("t3_tie_count", order_log.size() - idx, 32'd2);
        if (order_log.size() - idx == 2) begin
            check_value("t3_tie_first_a", order_log[idx], 32'd0);
            check_value("t3_tie_then_b", order_log[idx + 1], 32'd1);
        end
        check_value("t3_a_latency", la, 32'd3);
        check_value("t3_b_latency", lb, 32'd6);

        // Full clear sweep with an ignored second start pulse in the middle.
        issue(1'b0, 1'b1, 6'd63, 16'hBEEF, lat);
        bus.clr_start = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = CLR_VAL;
        @(negedge clk);
        bus.clr_start = 1'b0;
        bc = 0; ei = 0; bad = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 300; k++) begin
            if (!bus.clr_busy) break;
            bc++;
            bus.clr_start = (k == 10);
            if (bus.ram_load) begin
                if (bus.ram_address != 6'(ei) || bus.ram_in != CLR_VAL) bad++;
                if (first_k < 0) first_k = k;
                last_k = k;
                ei++;
            end
            @(negedge clk);
        end
        bus.clr_start = 1'b0;
        check_value("t4_busy_cycles", bc, 32'd65);
        check_value("t4_clear_writes", ei, 32'd64);
        check_value("t4_clear_addr_seq", bad, 32'd0);
        check_value("t4_clear_consecutive", last_k - first_k + 1, 32'd64);
        check_value("t4_busy_fell", bus.clr_busy, 32'd0);
        issue(1'b0, 1'b0, 6'd63, 16'd0, lat);
        check_value("t4_rd63_latency", lat, 32'd2);

        // Clear requested during A's ACCESS: A completes, sweep follows, B waits.
        issue(1'b0, 1'b1, 6'd10, 16'h1111, lat);
        @(negedge clk);
        fork
            begin int l; issue(1'b0, 1'b0, 6'd10, 16'd0, l); la = l; end
            begin
                @(negedge clk);
                bus.clr_start = 1'b1;
                for (int i = 0; i < 64; i++) ref_mem[i] = CLR_VAL;
                @(negedge clk);
                bus.clr_start = 1'b0;
            end
        join
        check_value("t5_a_latency", la, 32'd2);
        check_value("t5_busy_in_done", bus.clr_busy, 32'd1);
        repeat (2) @(negedge clk);
        check_value("t5_clear_start_load", bus.ram_load, 32'd1);
        check_value("t5_clear_start_addr", bus.ram_address, 32'd0);
        repeat (5) @(negedge clk);
        check_value("t5_busy_mid_clear", bus.clr_busy, 32'd1);
        issue(1'b1, 1'b0, 6'd20, 16'd0, lat);
        #1;
        check_value("t5_b_after_clear", b_ack_cyc - busy_fall_cyc, 32'd2);

        // Reset during a sweep leaves the tail of the memory untouched.
        issue(1'b0, 1'b1, 6'd0,  16'h0F0F, lat);
        issue(1'b0, 1'b1, 6'd29, 16'h2929, lat);
        issue(1'b0, 1'b1, 6'd30, 16'h3030, lat);
        issue(1'b0, 1'b1, 6'd45, 16'h4545, lat);
        issue(1'b0, 1'b1, 6'd63, 16'h6363, lat);
        bus.clr_start = 1'b1;
        for (int i = 0; i < 30; i++) ref_mem[i] = CLR_VAL;
        @(negedge clk);
        bus.clr_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.ram_load && bus.ram_address == 6'd29) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_value("t6_reached_addr29", found, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6_rst");
        reset = 1'b0;
        l0 = load_cnt;
        repeat (5) @(negedge clk);
        #1;
        check_value("t6_no_load_after_rst", load_cnt - l0, 32'd0);
        check_value("t6_busy_after_rst", bus.clr_busy, 32'd0);
        issue(1'b0, 1'b0, 6'd0,  16'd0, lat);
        issue(1'b0, 1'b0, 6'd29, 16'd0, lat);
        issue(1'b0, 1'b0, 6'd30, 16'd0, lat);
        issue(1'b0, 1'b0, 6'd45, 16'd0, lat);
        issue(1'b0, 1'b0, 6'd63, 16'd0, lat);

        repeat (3) @(negedge clk);
        #1;
        check_value("sb_a_drained", exp_a_q.size(), 32'd0);
        check_value("sb_b_drained", exp_b_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
